lmsm_mem_sequencer: RTL

//  Upstream master of the data-memory block. Executes one load-multiple (LM) or store-multiple (SM) op.

---
 rtl/lmsm_mem_sequencer_if.sv | 47 ++++
 rtl/lmsm_mem_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lmsm_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lmsm_mem_sequencer_if
// Description : Request, memory-access and register-file bundle of the LM/SM
//               sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface lmsm_mem_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
);
    logic              In_start;
    logic              In_is_store;
    logic [ADDR_W-1:0] In_base_addr;
    logic [NREG-1:0]   In_reg_list;
    logic              Out_busy;
    logic              Out_done;
    logic              Out_Mem_Access_en;
    logic              Out_Mem_Access_R_Wbar;
    logic [ADDR_W-1:0] Out_Mem_Access_addr;
    logic [DATA_W-1:0] Out_Mem_Write_data;
    logic [DATA_W-1:0] In_Mem_Read_data;
    logic [IDX_W-1:0]  Out_rf_rd_idx;
    logic [DATA_W-1:0] In_rf_rd_data;
    logic              Out_rf_wr_en;
    logic [IDX_W-1:0]  Out_rf_wr_idx;
    logic [DATA_W-1:0] Out_rf_wr_data;

    modport master (
        input  In_start, In_is_store, In_base_addr, In_reg_list,
        input  In_Mem_Read_data, In_rf_rd_data,
        output Out_busy, Out_done,
        output Out_Mem_Access_en, Out_Mem_Access_R_Wbar, Out_Mem_Access_addr, Out_Mem_Write_data,
        output Out_rf_rd_idx, Out_rf_wr_en, Out_rf_wr_idx, Out_rf_wr_data
    );

    modport slave (
        output In_start, In_is_store, In_base_addr, In_reg_list,
        output In_Mem_Read_data, In_rf_rd_data,
        input  Out_busy, Out_done,
        input  Out_Mem_Access_en, Out_Mem_Access_R_Wbar, Out_Mem_Access_addr, Out_Mem_Write_data,
        input  Out_rf_rd_idx, Out_rf_wr_en, Out_rf_wr_idx, Out_rf_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/lmsm_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lmsm_mem_sequencer
// Description : Load-multiple / store-multiple sequencer; one register
//               transfer per cycle, lowest register index first.
// Revision    : 1.0  initial release
// ============================================================================
module lmsm_mem_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
) (
    input  wire logic             In_clock,
    input  wire logic             In_reset,
    lmsm_mem_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   list_q, list_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              store_q, store_d;

    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rf_wdata;

    // Descending scan so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        w_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_addr = base_q + count_q;

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        base_d  = base_q;
        count_d = count_q;
        store_d = store_q;
        case (state_q)
            S_IDLE: begin
                if (bus.In_start) begin
                    store_d = bus.In_is_store;
                    base_d  = bus.In_base_addr;
                    list_d  = bus.In_reg_list;
                    count_d = '0;
                    state_d = (|bus.In_reg_list) ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                // x & (x-1) drops exactly the lowest set bit.
                list_d  = list_q & (list_q - {{(NREG-1){1'b0}}, 1'b1});
                count_d = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (list_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge In_clock) begin
        if (In_reset) begin
            state_q <= S_IDLE;
            list_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            base_q  <= base_d;
            count_q <= count_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        bus.Out_busy              = (state_q == S_ACCESS) || (state_q == S_DONE);
        bus.Out_done              = (state_q == S_DONE);
        bus.Out_Mem_Access_en     = 1'b0;
        bus.Out_Mem_Access_R_Wbar = 1'b1;
        bus.Out_Mem_Access_addr   = '0;
        bus.Out_rf_rd_idx         = '0;
        bus.Out_rf_wr_en          = 1'b0;
        bus.Out_rf_wr_idx         = '0;
        w_mem_wdata               = '0;
        w_rf_wdata                = '0;
        if (state_q == S_ACCESS) begin
            bus.Out_Mem_Access_en   = 1'b1;
            bus.Out_Mem_Access_addr = w_addr;
            if (store_q) begin
                bus.Out_Mem_Access_R_Wbar = 1'b0;
                bus.Out_rf_rd_idx         = w_idx;
                w_mem_wdata               = bus.In_rf_rd_data;
            end else begin
                bus.Out_rf_wr_en  = 1'b1;
                bus.Out_rf_wr_idx = w_idx;
                w_rf_wdata        = bus.In_Mem_Read_data;
            end
        end
    end

    assign bus.Out_Mem_Write_data = w_mem_wdata;
    assign bus.Out_rf_wr_data     = w_rf_wdata;

endmodule
`default_nettype wire
